// File: rtl/nmcu_pkg.sv
// nmcu_pkg: shared array geometry constants and the controller state type
package nmcu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PE_ROWS = 4;
  localparam int PE_COLS = 4;
  localparam int KLEN_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} pe_ctrl_state_e;
endpackage

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: command, operand-buffer and array-feed signals of the PE array controller
interface pe_array_ctrl_if #(
  parameter int ROWS = nmcu_pkg::PE_ROWS,
  parameter int COLS = nmcu_pkg::PE_COLS,
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int KLEN_WIDTH = nmcu_pkg::KLEN_WIDTH
);
  logic start_i;
  logic [KLEN_WIDTH-1:0] k_len_i;
  logic busy_o;
  logic done_o;
  logic result_valid_o;
  logic a_rd_en_o;
  logic [KLEN_WIDTH-1:0] a_rd_addr_o;
  logic [ROWS*DATA_WIDTH-1:0] a_rd_data_i;
  logic b_rd_en_o;
  logic [KLEN_WIDTH-1:0] b_rd_addr_o;
  logic [COLS*DATA_WIDTH-1:0] b_rd_data_i;
  logic arr_clr_o;
  logic arr_accum_en_o;
  logic [ROWS-1:0][DATA_WIDTH-1:0] arr_a_o;
  logic [COLS-1:0][DATA_WIDTH-1:0] arr_b_o;
  modport master (
    input start_i, k_len_i, a_rd_data_i, b_rd_data_i,
    output busy_o, done_o, result_valid_o, a_rd_en_o, a_rd_addr_o, b_rd_en_o, b_rd_addr_o,
    output arr_clr_o, arr_accum_en_o, arr_a_o, arr_b_o
  );
  modport slave (
    output start_i, k_len_i, a_rd_data_i, b_rd_data_i,
    input busy_o, done_o, result_valid_o, a_rd_en_o, a_rd_addr_o, b_rd_en_o, b_rd_addr_o,
    input arr_clr_o, arr_accum_en_o, arr_a_o, arr_b_o
  );
endinterface

// File: rtl/pe_array_ctrl_skew_line.sv
// skew_line: DEPTH-stage operand delay with synchronous clear; DEPTH 0 is a plain wire
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  localparam int L = DEPTH > 0 ? DEPTH : 1;
  logic [L-1:0][WIDTH-1:0] sr;
  // shift operands one stage per cycle, zeroed by reset or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else if (clr) sr <= '0;
    else begin
      sr[0] <= d;
      for (int n = 1; n < L; n++) sr[n] <= sr[n-1];
    end
  end
  assign q = DEPTH == 0 ? d : sr[L-1];
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences A/B buffer reads and feeds skewed operands into a ROWSxCOLS systolic array
module pe_array_ctrl #(
  parameter int ROWS = nmcu_pkg::PE_ROWS,
  parameter int COLS = nmcu_pkg::PE_COLS,
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int KLEN_WIDTH = nmcu_pkg::KLEN_WIDTH
) (
  input logic clk,
  input logic rst,
  pe_array_ctrl_if.master bus
);
  import nmcu_pkg::*;
  localparam logic [KLEN_WIDTH-1:0] DRAIN_LAST = KLEN_WIDTH'(ROWS + COLS - 1);
  pe_ctrl_state_e state, state_n;
  logic [KLEN_WIDTH-1:0] k_q, cnt, cnt_n;
  logic rd_vld, rv_q, accept, clr;
  logic [ROWS-1:0][DATA_WIDTH-1:0] a_in, a_out;
  logic [COLS-1:0][DATA_WIDTH-1:0] b_in, b_out;
  assign accept = state == IDLE && bus.start_i && bus.k_len_i != '0;
  assign clr = state == CLEAR;
  // next state and phase counter: FEED counts K reads, DRAIN counts ROWS+COLS flush cycles
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = accept ? CLEAR : IDLE;
      CLEAR: begin
        state_n = FEED;
        cnt_n = '0;
      end
      FEED: begin
        state_n = cnt == k_q - KLEN_WIDTH'(1) ? DRAIN : FEED;
        cnt_n = cnt == k_q - KLEN_WIDTH'(1) ? '0 : cnt + KLEN_WIDTH'(1);
      end
      DRAIN: begin
        state_n = cnt == DRAIN_LAST ? DONE : DRAIN;
        cnt_n = cnt == DRAIN_LAST ? '0 : cnt + KLEN_WIDTH'(1);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, counter, latched K, read-data-valid tracking and result-valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k_q <= '0;
      rd_vld <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd_vld <= state == FEED;
      if (accept) begin
        k_q <= bus.k_len_i;
        rv_q <= 1'b0;
      end else if (state == DONE) rv_q <= 1'b1;
    end
  end
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = state == DONE;
  assign bus.result_valid_o = rv_q;
  assign bus.a_rd_en_o = state == FEED;
  assign bus.b_rd_en_o = state == FEED;
  assign bus.a_rd_addr_o = state == FEED ? cnt : '0;
  assign bus.b_rd_addr_o = state == FEED ? cnt : '0;
  assign bus.arr_clr_o = clr;
  assign bus.arr_accum_en_o = state == FEED || state == DRAIN;
  assign a_in = rd_vld ? bus.a_rd_data_i : '0;
  assign b_in = rd_vld ? bus.b_rd_data_i : '0;
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    skew_line #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_skew (
      .clk(clk), .rst(rst), .clr(clr), .d(a_in[i]), .q(a_out[i])
    );
  end
  for (genvar j = 0; j < COLS; j++) begin : g_col
    skew_line #(.DEPTH(j), .WIDTH(DATA_WIDTH)) u_skew (
      .clk(clk), .rst(rst), .clr(clr), .d(b_in[j]), .q(b_out[j])
    );
  end
  assign bus.arr_a_o = a_out;
  assign bus.arr_b_o = b_out;
endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter ROWS, default 4, array row count.
REQ-002 Parameter COLS, default 4, array column count.
REQ-003 Parameter DATA_WIDTH, default nmcu_pkg::DATA_WIDTH, operand element width.
REQ-004 Parameter KLEN_WIDTH, default 8, width of the inner-dimension length.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start_i  in  1  request one matrix-multiply pass, sampled in IDLE only.
REQ-008 k_len_i  in  KLEN_WIDTH  inner dimension K, sampled with start_i.
REQ-009 busy_o  out  1  high in every state except IDLE.
REQ-010 done_o  out  1  one-cycle pulse, pass complete.
REQ-011 result_valid_o  out  1  array results final and stable.
REQ-012 a_rd_en_o / a_rd_addr_o  out  1 / KLEN_WIDTH  A-buffer read; word k packs A[0..ROWS-1][k], element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 a_rd_data_i  in  ROWS*DATA_WIDTH  A-buffer data, valid one cycle after a_rd_en_o.
REQ-014 b_rd_en_o / b_rd_addr_o  out  1 / KLEN_WIDTH  B-buffer read; word k packs B[k][0..COLS-1].
REQ-015 b_rd_data_i  in  COLS*DATA_WIDTH  B-buffer data, one-cycle latency.
REQ-016 arr_clr_o  out  1  clears array psums and operand registers (drives the array's reset).
REQ-017 arr_accum_en_o  out  1  array accumulate enable.
REQ-018 arr_a_o  out  [ROWS][DATA_WIDTH]  skewed row operands into array column 0.
REQ-019 arr_b_o  out  [COLS][DATA_WIDTH]  skewed column operands into array row 0.

Function
REQ-020 States: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-021 IDLE -> CLEAR when start_i=1 and k_len_i!=0; K latched; result_valid_o cleared that edge.
REQ-022 start_i with k_len_i=0, or start_i in any non-IDLE state, is ignored with no side effect.
REQ-023 CLEAR lasts 1 cycle with arr_clr_o=1; all skew registers zeroed.
REQ-024 FEED lasts K cycles; in FEED cycle f (0..K-1) a_rd_en_o=b_rd_en_o=1, both addresses = f.
REQ-025 Row i operand k appears on arr_a_o[i] in cycle k+1+i (FEED cycle 0 = cycle 0); column j operand k on arr_b_o[j] in cycle k+1+j; delay via i (j) registers after read data.
REQ-026 arr_a_o/arr_b_o are zero in every cycle not carrying a valid element.
REQ-027 DRAIN lasts ROWS+COLS cycles (cycles K..K+ROWS+COLS-1).
REQ-028 arr_accum_en_o=1 throughout FEED and DRAIN, 0 otherwise.
REQ-029 DONE lasts 1 cycle (cycle K+ROWS+COLS): done_o=1, result_valid_o set, -> IDLE.
REQ-030 Latency: start_i sampled in cycle s -> done_o in cycle s+K+ROWS+COLS+2.
REQ-031 Read addresses wrap nowhere: maximum address = K-1 <= 2^KLEN_WIDTH-2.
REQ-032 No arithmetic in this block; operands pass through bit-exact (signed interpretation is the array's).

Reset
REQ-033 rst=1 asynchronously forces IDLE, all outputs 0, skew registers 0, K register 0, at any state including mid-FEED.
REQ-034 After rst deassertion, first start_i is accepted normally; no partial pass resumes.

Structure
REQ-035 nmcu_pkg holds PE_ROWS, PE_COLS, KLEN_WIDTH constants and pe_ctrl_state_e enum.
REQ-036 One sub-module skew_line (parameterized depth, width, synchronous clear) per row/column delay.
REQ-037 FSM and counters live in pe_array_ctrl; total RTL 120-400 lines.

Verification (bench instantiates pe_array_ctrl + 4x4 array + two buffer models)
REQ-038 K=1, all A=2, all B=3 -> every result 6, done_o at s+11, result_valid_o high after.
REQ-039 K=4, A=identity, B[k][j]=k*4+j -> result[i][j]=i*4+j; A=-1 row-wise -> signed negated sums.
REQ-040 Two back-to-back passes (second start in cycle after done) -> second results not polluted by first; arr_clr_o pulses once per pass.
REQ-041 start_i pulsed during FEED and start_i with k_len_i=0 in IDLE -> no state change, no extra reads.
REQ-042 rst asserted in FEED cycle 2 of K=8 -> all outputs 0 same cycle, IDLE; fresh K=2 pass then correct.
REQ-043 K=255 -> last read address 254, done_o at s+265.
